// File: rtl/alu_issue.sv
// Operand-issue stage ahead of the ALU: resolves operands (RF/immediate/bypass),
// stalls on pending producers and feeds the ALU from a registered 2-entry skid buffer.
package multicore_pkg;
   parameter int DATA_SIZE = 32;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } t_aluop;
endpackage

module alu_issue #(
   parameter int DATA_SIZE  = multicore_pkg::DATA_SIZE,
   parameter int REG_ADDR_W = 5
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_flush,
   input  logic                    i_dec_valid,
   output logic                    o_dec_ready,
   input  multicore_pkg::t_aluop   i_dec_funct,
   input  logic [REG_ADDR_W-1:0]   i_dec_rs1,
   input  logic [REG_ADDR_W-1:0]   i_dec_rs2,
   input  logic [REG_ADDR_W-1:0]   i_dec_rd,
   input  logic                    i_dec_use_imm,
   input  logic [DATA_SIZE-1:0]    i_dec_imm,
   input  logic [DATA_SIZE-1:0]    i_rf_rs1_data,
   input  logic [DATA_SIZE-1:0]    i_rf_rs2_data,
   input  logic                    i_ex_fwd_valid,
   input  logic [REG_ADDR_W-1:0]   i_ex_fwd_rd,
   input  logic [DATA_SIZE-1:0]    i_ex_fwd_data,
   input  logic                    i_wb_fwd_valid,
   input  logic [REG_ADDR_W-1:0]   i_wb_fwd_rd,
   input  logic [DATA_SIZE-1:0]    i_wb_fwd_data,
   input  logic                    i_pend_valid,
   input  logic [REG_ADDR_W-1:0]   i_pend_rd,
   output logic                    o_alu_valid,
   input  logic                    i_alu_ready,
   output multicore_pkg::t_aluop   o_alu_funct,
   output logic [DATA_SIZE-1:0]    o_alu_op_a,
   output logic [DATA_SIZE-1:0]    o_alu_op_b,
   output logic [REG_ADDR_W-1:0]   o_alu_rd
);
   import multicore_pkg::*;

   localparam int SHW = $clog2(DATA_SIZE);
   localparam logic [DATA_SIZE-1:0] SHIFT_MASK = {{(DATA_SIZE-SHW){1'b0}}, {SHW{1'b1}}};

   typedef struct packed {
      t_aluop                  funct;
      logic [DATA_SIZE-1:0]    op_a;
      logic [DATA_SIZE-1:0]    op_b;
      logic [REG_ADDR_W-1:0]   rd;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t state_q, state_d;
   entry_t head_q, head_d;
   entry_t tail_q, tail_d;
   entry_t new_entry;

   logic [REG_ADDR_W-1:0] src_idx [2];
   logic [DATA_SIZE-1:0]  src_rf  [2];
   logic [DATA_SIZE-1:0]  src_val [2];
   logic [1:0]            src_used;
   logic [1:0]            src_haz;

   logic hazard, accept, pop;
   logic [DATA_SIZE-1:0] op_b_raw;

   assign src_idx[0] = i_dec_rs1;
   assign src_idx[1] = i_dec_rs2;
   assign src_rf[0]  = i_rf_rs1_data;
   assign src_rf[1]  = i_rf_rs2_data;
   assign src_used   = {!i_dec_use_imm, 1'b1};

   // x0 never forwards or hazards; EX bypass wins over WB.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         always_comb begin
            src_val[gi] = src_rf[gi];
            if (src_idx[gi] == '0)
               src_val[gi] = '0;
            else if (i_ex_fwd_valid && (i_ex_fwd_rd == src_idx[gi]))
               src_val[gi] = i_ex_fwd_data;
            else if (i_wb_fwd_valid && (i_wb_fwd_rd == src_idx[gi]))
               src_val[gi] = i_wb_fwd_data;
         end
         assign src_haz[gi] = src_used[gi] && i_pend_valid && (i_pend_rd != '0)
                              && (i_pend_rd == src_idx[gi]);
      end
   endgenerate

   assign hazard      = |src_haz;
   assign o_dec_ready = (state_q != TWO) && !hazard && !i_flush;
   assign accept      = i_dec_valid && o_dec_ready;
   assign pop         = o_alu_valid && i_alu_ready;

   assign op_b_raw = i_dec_use_imm ? i_dec_imm : src_val[1];

   always_comb begin
      new_entry.funct = i_dec_funct;
      new_entry.op_a  = src_val[0];
      new_entry.op_b  = op_b_raw;
      new_entry.rd    = i_dec_rd;
      if (i_dec_funct == ALU_SLL || i_dec_funct == ALU_SRL || i_dec_funct == ALU_SRA)
         new_entry.op_b = op_b_raw & SHIFT_MASK;
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               head_d  = new_entry;
            end
         end
         ONE: begin
            if (accept && pop) begin
               head_d = new_entry;
            end else if (accept) begin
               state_d = TWO;
               tail_d  = new_entry;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               state_d = ONE;
               head_d  = tail_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush only drops occupancy; stale head values are hidden by o_alu_valid.
      if (i_flush)
         state_d = EMPTY;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= EMPTY;
         head_q.funct <= ALU_ADD;
         head_q.op_a  <= '0;
         head_q.op_b  <= '0;
         head_q.rd    <= '0;
         tail_q.funct <= ALU_ADD;
         tail_q.op_a  <= '0;
         tail_q.op_b  <= '0;
         tail_q.rd    <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign o_alu_valid = (state_q != EMPTY);
   assign o_alu_funct = head_q.funct;
   assign o_alu_op_a  = head_q.op_a;
   assign o_alu_op_b  = head_q.op_b;
   assign o_alu_rd    = head_q.rd;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: inputs change on the falling edge, ready is
// checked just after, registered outputs are checked 1 ns after the rising edge.
module tb_alu_issue;
   import multicore_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst, flush;
   logic          dec_valid, dec_ready;
   t_aluop        dec_funct;
   logic [AW-1:0] dec_rs1, dec_rs2, dec_rd;
   logic          dec_use_imm;
   logic [DW-1:0] dec_imm, rf1, rf2;
   logic          ex_v, wb_v, pend_v;
   logic [AW-1:0] ex_rd, wb_rd, pend_rd;
   logic [DW-1:0] ex_d, wb_d;
   logic          alu_valid, alu_ready;
   t_aluop        alu_funct;
   logic [DW-1:0] alu_a, alu_b;
   logic [AW-1:0] alu_rd;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_issue #(.DATA_SIZE(DW), .REG_ADDR_W(AW)) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush),
      .i_dec_valid(dec_valid), .o_dec_ready(dec_ready),
      .i_dec_funct(dec_funct), .i_dec_rs1(dec_rs1), .i_dec_rs2(dec_rs2), .i_dec_rd(dec_rd),
      .i_dec_use_imm(dec_use_imm), .i_dec_imm(dec_imm),
      .i_rf_rs1_data(rf1), .i_rf_rs2_data(rf2),
      .i_ex_fwd_valid(ex_v), .i_ex_fwd_rd(ex_rd), .i_ex_fwd_data(ex_d),
      .i_wb_fwd_valid(wb_v), .i_wb_fwd_rd(wb_rd), .i_wb_fwd_data(wb_d),
      .i_pend_valid(pend_v), .i_pend_rd(pend_rd),
      .o_alu_valid(alu_valid), .i_alu_ready(alu_ready),
      .o_alu_funct(alu_funct), .o_alu_op_a(alu_a), .o_alu_op_b(alu_b), .o_alu_rd(alu_rd)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
      $display("check %-14s observed=%0h expected=%0h", tag, got, exp);
   endtask

   task automatic issue(input t_aluop f, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic [AW-1:0] rd, input logic ui, input logic [DW-1:0] imm);
      dec_valid   = 1'b1;
      dec_funct   = f;
      dec_rs1     = r1;
      dec_rs2     = r2;
      dec_rd      = rd;
      dec_use_imm = ui;
      dec_imm     = imm;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; dec_valid = 1'b0; dec_funct = ALU_ADD;
      dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_use_imm = 1'b0; dec_imm = '0;
      rf1 = '0; rf2 = '0; ex_v = 1'b0; wb_v = 1'b0; pend_v = 1'b0;
      ex_rd = '0; wb_rd = '0; pend_rd = '0; ex_d = '0; wb_d = '0; alu_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0; #1;
      chk("rst_valid", alu_valid, 0);
      chk("rst_funct", alu_funct, ALU_ADD);
      chk("rst_op_a", alu_a, 0);
      chk("rst_op_b", alu_b, 0);
      chk("rst_rd", alu_rd, 0);
      chk("rst_ready", dec_ready, 1);

      // Single issue from RF
      @(negedge clk);
      issue(ALU_ADD, 5'd3, 5'd4, 5'd1, 1'b0, '0); rf1 = 5; rf2 = 7;
      after_edge();
      chk("iss_valid", alu_valid, 1);
      chk("iss_op_a", alu_a, 5);
      chk("iss_op_b", alu_b, 7);
      chk("iss_funct", alu_funct, ALU_ADD);
      chk("iss_rd", alu_rd, 1);

      // Forward priority: EX over WB over RF; pop and accept together each cycle
      @(negedge clk);
      alu_ready = 1'b1;
      issue(ALU_SUB, 5'd6, 5'd7, 5'd2, 1'b0, '0);
      rf1 = 32'h33; rf2 = 32'h44;
      ex_v = 1'b1; ex_rd = 5'd6; ex_d = 32'h11;
      wb_v = 1'b1; wb_rd = 5'd6; wb_d = 32'h22;
      after_edge();
      chk("fwd_ex", alu_a, 32'h11);
      chk("fwd_rf_b", alu_b, 32'h44);
      chk("fwd_funct", alu_funct, ALU_SUB);
      @(negedge clk); ex_v = 1'b0; wb_rd = 5'd7; ex_rd = 5'd7;
      after_edge();
      chk("fwd_rf_a", alu_a, 32'h33);
      chk("fwd_wb_b", alu_b, 32'h22);
      @(negedge clk); wb_rd = 5'd6;
      after_edge();
      chk("fwd_wb", alu_a, 32'h22);
      @(negedge clk);
      issue(ALU_ADD, 5'd0, 5'd0, 5'd3, 1'b0, '0);
      ex_v = 1'b1; ex_rd = 5'd0; wb_rd = 5'd0;
      after_edge();
      chk("fwd_x0_a", alu_a, 0);
      chk("fwd_x0_b", alu_b, 0);
      chk("fwd_valid", alu_valid, 1);
      @(negedge clk); dec_valid = 1'b0; ex_v = 1'b0; wb_v = 1'b0;
      after_edge();
      chk("drain_valid", alu_valid, 0);

      // Hazard on rs2, then same instruction with immediate
      @(negedge clk);
      issue(ALU_ADD, 5'd1, 5'd9, 5'd4, 1'b0, 32'h40);
      rf1 = 2; rf2 = 99; pend_v = 1'b1; pend_rd = 5'd9; #1;
      chk("haz_ready", dec_ready, 0);
      after_edge();
      chk("haz_valid", alu_valid, 0);
      @(negedge clk); dec_use_imm = 1'b1; #1;
      chk("haz_imm_rdy", dec_ready, 1);
      after_edge();
      chk("haz_imm_vld", alu_valid, 1);
      chk("haz_imm_b", alu_b, 32'h40);
      chk("haz_imm_a", alu_a, 2);
      @(negedge clk); dec_rs1 = 5'd9; #1;
      chk("haz_rs1_rdy", dec_ready, 0);
      pend_v = 1'b0;

      // Shift masking
      @(negedge clk);
      issue(ALU_SLL, 5'd1, 5'd0, 5'd5, 1'b1, 32'h25);
      after_edge();
      chk("sll_b", alu_b, 5);
      chk("sll_funct", alu_funct, ALU_SLL);
      @(negedge clk); dec_funct = ALU_XOR;
      after_edge();
      chk("xor_b", alu_b, 32'h25);
      @(negedge clk); dec_funct = ALU_SRA; dec_imm = 32'hFFFF_FFE3;
      after_edge();
      chk("sra_b", alu_b, 3);
      @(negedge clk); dec_valid = 1'b0;
      after_edge();
      chk("shift_drain", alu_valid, 0);

      // Backpressure: 2 accepted, third refused, head stable, in-order drain
      @(negedge clk); alu_ready = 1'b0;
      issue(ALU_OR, 5'd0, 5'd0, 5'd11, 1'b1, 32'hA1); #1;
      chk("bp_rdy0", dec_ready, 1);
      after_edge();
      chk("bp_b0", alu_b, 32'hA1);
      @(negedge clk); dec_imm = 32'hB2; dec_rd = 5'd12; #1;
      chk("bp_rdy1", dec_ready, 1);
      after_edge();
      chk("bp_hold1", alu_b, 32'hA1);
      @(negedge clk); dec_imm = 32'hC3; dec_rd = 5'd13; #1;
      chk("bp_rdy2", dec_ready, 0);
      after_edge();
      chk("bp_hold2", alu_b, 32'hA1);
      chk("bp_hold_rd", alu_rd, 11);
      @(negedge clk); dec_valid = 1'b0; alu_ready = 1'b1;
      after_edge();
      chk("bp_drain_vld", alu_valid, 1);
      chk("bp_drain_b", alu_b, 32'hB2);
      chk("bp_drain_rd", alu_rd, 12);
      after_edge();
      chk("bp_empty", alu_valid, 0);

      // Flush with buffer full, accept and pop requested
      @(negedge clk); alu_ready = 1'b0;
      issue(ALU_AND, 5'd0, 5'd0, 5'd14, 1'b1, 32'h1);
      after_edge();
      @(negedge clk); dec_imm = 32'h2;
      after_edge();
      @(negedge clk); flush = 1'b1; alu_ready = 1'b1; dec_imm = 32'h3; #1;
      chk("fl_ready", dec_ready, 0);
      after_edge();
      chk("fl_valid", alu_valid, 0);
      @(negedge clk); flush = 1'b0; dec_valid = 1'b0; #1;
      chk("fl_rdy_after", dec_ready, 1);
      after_edge();
      chk("fl_still_empty", alu_valid, 0);

      // Reset mid-operation
      @(negedge clk); alu_ready = 1'b0;
      issue(ALU_SLT, 5'd0, 5'd0, 5'd15, 1'b1, 32'h77);
      after_edge();
      chk("mr_pre", alu_valid, 1);
      @(negedge clk); dec_valid = 1'b0; rst = 1'b1;
      after_edge();
      chk("mr_valid", alu_valid, 0);
      chk("mr_funct", alu_funct, ALU_ADD);
      chk("mr_op_b", alu_b, 0);
      chk("mr_rd", alu_rd, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-issue stage directly upstream of the ALU in each core's execute path. It accepts decoded ALU instructions over a valid/ready handshake and resolves both operands from the register file, the immediate, or forwarding buses. It stalls on unresolved producers and presents registered `i_funct` / `i_op_a` / `i_op_b` values to the ALU through a 2-entry skid buffer, so the decode side sees no combinational path from downstream ready.

## Interface
- `DATA_SIZE`, default from `multicore_pkg`: operand and result width.
- `REG_ADDR_W`, default 5: register index width.
- Clock and reset: one clock; reset is synchronous and active-high (`i_clk`, `i_rst`).
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous active-high reset.
- `i_flush`  in  1  discard all buffered and incoming instructions.
- `i_dec_valid`  in  1  decoded instruction present.
- `o_dec_ready`  out  1  instruction accepted this cycle when high with valid.
- `i_dec_funct`  in  `t_aluop`  ALU operation.
- `i_dec_rs1`, `i_dec_rs2`, `i_dec_rd`  in  `REG_ADDR_W`  source and destination indices.
- `i_dec_use_imm`  in  1  op_b is taken from `i_dec_imm` instead of rs2.
- `i_dec_imm`  in  `DATA_SIZE`  sign-extended immediate.
- `i_rf_rs1_data`, `i_rf_rs2_data`  in  `DATA_SIZE`  register-file read data, same cycle as dec.
- `i_ex_fwd_valid`, `i_ex_fwd_rd`, `i_ex_fwd_data`  in  1/`REG_ADDR_W`/`DATA_SIZE`  ALU-result bypass.
- `i_wb_fwd_valid`, `i_wb_fwd_rd`, `i_wb_fwd_data`  in  1/`REG_ADDR_W`/`DATA_SIZE`  writeback bypass.
- `i_pend_valid`, `i_pend_rd`  in  1/`REG_ADDR_W`  in-flight producer whose data is not yet available (for example, a load).
- `o_alu_valid`  out  1  head entry valid.
- `i_alu_ready`  in  1  ALU side consumes the head this cycle.
- `o_alu_funct`  out  `t_aluop`; `o_alu_op_a`, `o_alu_op_b`  out  `DATA_SIZE`; `o_alu_rd`  out  `REG_ADDR_W`.

## Operation
- **Source use:** rs1 is always used. rs2 is used only when `i_dec_use_imm` is 0.
- **Operand resolution** (per used source, evaluated in the accept cycle):
  - Index 0 resolves to 0 and never forwards or hazards.
  - Otherwise use EX bypass on rd match, else WB bypass on rd match, else RF data. EX has priority over WB.
- **op_b source:** op_b = `i_dec_imm` when `i_dec_use_imm` is 1.
- **Shift masking:** for SLL, SRL and SRA, op_b is masked to its low $clog2(DATA_SIZE) bits. Other ops pass op_b unmodified.
- **Hazard:** `i_pend_valid` with `i_pend_rd` ≠ 0 matching a used source. Hazard takes priority over any bypass match.
- **Ready:** `o_dec_ready = (count < 2) && !hazard && !i_flush`.
- **Accept:** `i_dec_valid && o_dec_ready`. The fully resolved entry {funct, op_a, op_b, rd} is written into the buffer. Operands are never re-resolved after acceptance.
- **Buffer states:**
  - EMPTY (count 0): accept → ONE.
  - ONE: accept without pop → TWO; pop without accept → EMPTY; both at once → stay ONE, new entry becomes head.
  - TWO: pop → ONE, second entry becomes head. No accept in TWO.
- **Pop:** `o_alu_valid && i_alu_ready`.
- **Head output:** `o_alu_*` always show the head entry. Head values hold stable while `o_alu_valid` is high and `i_alu_ready` is low.
- **Flush:** `i_flush` forces count to 0 on the next edge and blocks acceptance in the same cycle. A flush overrides simultaneous accept and pop.
- **Reset:** count 0, `o_alu_valid` 0, `o_alu_funct` = ADD, `o_alu_op_a` = `o_alu_op_b` = 0, `o_alu_rd` = 0. `o_dec_ready` is therefore 1 in the first post-reset cycle, absent a hazard.

## Timing
- Latency: accepted in cycle N → `o_alu_valid` high in cycle N+1 (from EMPTY, or ONE with a pop in N).
- Throughput: 1 instruction per cycle while `i_alu_ready` is held high.
- Combinational paths:
  - `o_dec_ready` depends on registered count, `i_flush`, and the hazard compare.
  - No combinational path from `i_alu_ready` to `o_dec_ready`.
  - `o_alu_*` are registered.
- Reset mid-operation: buffered entries are lost and outputs take their reset values on the reset edge.

## Test plan
- **Reset then single issue:** ADD, rs1=x3 (RF 5), rs2=x4 (RF 7) → cycle+1: `o_alu_valid`=1, op_a=5, op_b=7, funct=ADD.
- **Forward priority:** rs1=x6, EX bypass x6=0x11, WB bypass x6=0x22, RF=0x33 → op_a=0x11. Drop EX: op_a=0x22. Repeat with rs1=x0 and all bypasses on x0 → op_a=0.
- **Hazard:** `i_pend_valid`=1, `i_pend_rd`=x9, instruction rs2=x9 with `use_imm`=0 → `o_dec_ready`=0. Same instruction with `use_imm`=1 → accepted.
- **Shift mask:** SLL with `use_imm`=1, imm=0x25, DATA_SIZE=32 → op_b=5. XOR with imm=0x25 → op_b=0x25.
- **Backpressure:** hold `i_alu_ready`=0 and offer 3 instructions → 2 accepted, `o_dec_ready`=0 on the third, head stable. Release ready → in-order drain, 1 per cycle.
- **Flush:** with the buffer at TWO, assert `i_flush` together with `i_dec_valid` and `i_alu_ready` → next cycle `o_alu_valid`=0, nothing accepted.
